// File: rtl/led_fade_driver.sv
// rtl/led_fade_driver.sv - PWM LED output stage that fades each channel toward its on/off target
module led_fade_driver #(
  parameter int N_LED    = 6,
  parameter int PWM_BITS = 8,
  parameter int FADE_DIV = 105469
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_LED-1:0] pattern,
  input  logic             pattern_valid,
  input  logic             fade_en,
  output logic             busy,
  output logic [N_LED-1:0] led_n
);

  localparam int DIV_W = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_DIV - 1);
  localparam logic [PWM_BITS-1:0] MAX = '1;

  typedef enum logic [1:0] {CH_OFF, CH_RISING, CH_ON, CH_FALLING} ch_state_t;

  logic [N_LED-1:0]                target, target_nxt;
  logic [N_LED-1:0][PWM_BITS-1:0]  level, level_nxt;
  logic [PWM_BITS-1:0]             pwm_cnt;
  logic [DIV_W-1:0]                div_cnt;
  logic                            tick;
  logic                            busy_nxt;
  ch_state_t                       ch_state [N_LED];

  // Targets are only ever fully off or fully on, so one bit per channel suffices.
  function automatic logic [PWM_BITS-1:0] full_level(input logic on);
    return on ? MAX : '0;
  endfunction

  assign tick = (div_cnt == DIV_LAST);

  always_comb begin
    target_nxt = pattern_valid ? pattern : target;
    level_nxt  = level;
    busy_nxt   = 1'b0;
    for (int i = 0; i < N_LED; i++) begin
      ch_state[i] = CH_OFF;
      if (level[i] < full_level(target[i]))
        ch_state[i] = CH_RISING;
      else if (level[i] > full_level(target[i]))
        ch_state[i] = CH_FALLING;
      else if (target[i])
        ch_state[i] = CH_ON;

      // Stepping uses the current target, so a strobe on a tick edge takes effect one edge later.
      if (!fade_en) begin
        level_nxt[i] = full_level(target[i]);
      end else if (tick) begin
        case (ch_state[i])
          CH_RISING:  level_nxt[i] = level[i] + 1'b1;
          CH_FALLING: level_nxt[i] = level[i] - 1'b1;
          default:    level_nxt[i] = level[i];
        endcase
      end

      busy_nxt = busy_nxt | (level_nxt[i] != full_level(target_nxt[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      pwm_cnt <= '0;
      target  <= '0;
      level   <= '0;
      busy    <= 1'b0;
      led_n   <= '1;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
      target  <= target_nxt;
      level   <= level_nxt;
      busy    <= busy_nxt;
      for (int i = 0; i < N_LED; i++)
        led_n[i] <= ~(level[i] > pwm_cnt);
    end
  end

endmodule
